// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX
  } md_state_t;

  localparam int unsigned DIV_ITERS = 32;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // One extra bit: the shifted remainder can reach 2*divisor-1, beyond WIDTH bits.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with single-cycle multiply/moves and a multi-cycle restoring divider.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  md_state_t        state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] rem_r, quo_r, divisor_r;
  logic             q_neg, r_neg, div_zero;

  logic [WIDTH-1:0]   rem_next, quo_next;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   abs1, abs2, quo_fix, rem_fix;
  logic               is_sdiv;

  always_comb begin
    is_sdiv = (op == MD_DIV);
    // Low 2W bits of the product of sign-extended operands equal the signed product.
    prod_s  = {{WIDTH{op1[WIDTH-1]}}, op1} * {{WIDTH{op2[WIDTH-1]}}, op2};
    prod_u  = {{WIDTH{1'b0}}, op1} * {{WIDTH{1'b0}}, op2};
    abs1    = (is_sdiv && op1[WIDTH-1]) ? ('0 - op1) : op1;
    abs2    = (is_sdiv && op2[WIDTH-1]) ? ('0 - op2) : op2;
    // With a zero divisor every trial subtract succeeds: rem ends as |op1|, so the
    // remainder sign restores op1 while the quotient is forced to all ones.
    quo_fix = div_zero ? '1 : (q_neg ? ('0 - quo_r) : quo_r);
    rem_fix = r_neg ? ('0 - rem_r) : rem_r;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem     (rem_r),
    .quo     (quo_r),
    .divisor (divisor_r),
    .rem_next(rem_next),
    .quo_next(quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      divisor_r <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !kill) begin
            case (op)
              MD_MULT: begin
                {hi, lo} <= prod_s;
                done     <= 1'b1;
              end
              MD_MULTU: begin
                {hi, lo} <= prod_u;
                done     <= 1'b1;
              end
              MD_MTHI: begin
                hi   <= op1;
                done <= 1'b1;
              end
              MD_MTLO: begin
                lo   <= op1;
                done <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                rem_r     <= '0;
                quo_r     <= abs1;
                divisor_r <= abs2;
                q_neg     <= is_sdiv && (op1[WIDTH-1] ^ op2[WIDTH-1]);
                r_neg     <= is_sdiv && op1[WIDTH-1];
                div_zero  <= (op2 == '0);
                counter   <= '0;
                busy      <= 1'b1;
                state     <= DIV;
              end
              default: ;
            endcase
          end
        end
        DIV: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem_r   <= rem_next;
            quo_r   <= quo_next;
            counter <= counter + 1'b1;
            if (counter == LastIter) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!kill) begin
            lo   <= quo_fix;
            hi   <= rem_fix;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed plan vectors plus randomized ops vs a model.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  op;
  logic [31:0] op1, op2;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  int lat, dones, tail_done;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .op1  (op1),
    .op2  (op2),
    .kill (kill),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  // Architectural model: results from plain integer arithmetic.
  function automatic void ref_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    case (o)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); {exp_hi, exp_lo} = p; end
      3'd1: {exp_hi, exp_lo} = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) begin exp_lo = 32'hFFFF_FFFF; exp_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          exp_lo = 32'h8000_0000; exp_hi = 0;
        end else begin
          sa = $signed(a); sb = $signed(b);
          exp_lo = sa / sb; exp_hi = sa % sb;
        end
      end
      3'd3: begin
        if (b == 0) begin exp_lo = 32'hFFFF_FFFF; exp_hi = a; end
        else begin exp_lo = a / b; exp_hi = a % b; end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endfunction

  // Issues one op and measures edges until busy falls plus done pulses seen.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    dones = (done === 1'b1) ? 1 : 0;
    while (busy === 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      dones += (done === 1'b1) ? 1 : 0;
    end
    @(posedge clk); #1;
    tail_done = (done === 1'b1) ? 1 : 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = '0; op1 = '0; op2 = '0;
    #12;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h required all zero", busy, done, hi, lo);
    end
    @(negedge clk); reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2};
    logic [31:0] t_a  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd100,
                              32'h1234_5678, 32'h8000_0000};
    logic [31:0] t_b  [6] = '{32'd3, 32'd3, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] t_hi [6] = '{32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'd2, 32'h1234_5678, 32'd0};
    logic [31:0] t_lo [6] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd14,
                              32'hFFFF_FFFF, 32'h8000_0000};
    int t_lat [6] = '{0, 0, 33, 33, 33, 33};
    for (int i = 0; i < 6; i++) begin
      do_op(t_op[i], t_a[i], t_b[i]);
      checks++;
      if (hi !== t_hi[i] || lo !== t_lo[i]) begin
        failures++;
        $display("FAIL directed[%0d] result: hi=%h lo=%h required hi=%h lo=%h",
                 i, hi, lo, t_hi[i], t_lo[i]);
      end
      checks++;
      if (lat !== t_lat[i] || dones !== 1 || tail_done !== 0) begin
        failures++;
        $display("FAIL directed[%0d] timing: latency=%0d dones=%0d tail=%0d required %0d/1/0",
                 i, lat, dones, tail_done, t_lat[i]);
      end
      exp_hi = t_hi[i]; exp_lo = t_lo[i];
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    int          want_lat, want_dones;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      ref_apply(o, a, b);
      want_lat   = (o == 3'd2 || o == 3'd3) ? 33 : 0;
      want_dones = (o <= 3'd5) ? 1 : 0;
      do_op(o, a, b);
      checks++;
      if (hi !== exp_hi || lo !== exp_lo || lat !== want_lat || dones !== want_dones) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d dones=%0d required hi=%h lo=%h lat=%0d dones=%0d",
                 i, o, a, b, hi, lo, lat, dones, exp_hi, exp_lo, want_lat, want_dones);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); start = 1'b1; op = 3'd4; op1 = 32'h1111_1111;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || hi !== 32'h1111_1111) begin
      failures++;
      $display("FAIL b2b_mthi: done=%b hi=%h required 1 11111111", done, hi);
    end
    @(negedge clk); op = 3'd5; op1 = 32'h2222_2222;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || lo !== 32'h2222_2222 || hi !== 32'h1111_1111) begin
      failures++;
      $display("FAIL b2b_mtlo: done=%b hi=%h lo=%h required 1 11111111 22222222", done, hi, lo);
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_tail: done=%b required 0", done);
    end
    exp_hi = 32'h1111_1111; exp_lo = 32'h2222_2222;
  endtask

  task automatic test_kill();
    int dseen;
    do_op(3'd4, 32'hAAAA_0000, 32'd0);
    exp_hi = 32'hAAAA_0000;
    @(negedge clk); start = 1'b1; op = 3'd2; op1 = 32'd50; op2 = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL kill_busy_start: busy=%b required 1", busy);
    end
    dseen = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = (i == 10);
      op = 3'd0; op1 = 32'h0000_FFFF; op2 = 32'h0000_FFFF;
      kill = (i == 20);
      @(posedge clk); #1;
      dseen += (done === 1'b1) ? 1 : 0;
    end
    @(negedge clk); start = 1'b0; kill = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo || dseen !== 0) begin
      failures++;
      $display("FAIL kill_abort: busy=%b hi=%h lo=%h dones=%0d required 0 %h %h 0",
               busy, hi, lo, dseen, exp_hi, exp_lo);
    end
    // kill together with start in IDLE drops the start
    @(negedge clk); start = 1'b1; kill = 1'b1; op = 3'd5; op1 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || lo !== exp_lo || busy !== 1'b0) begin
      failures++;
      $display("FAIL kill_idle_start: done=%b lo=%h busy=%b required 0 %h 0", done, lo, busy, exp_lo);
    end
    @(negedge clk); start = 1'b0; kill = 1'b0;
    // kill on the fix edge suppresses the write
    @(negedge clk); start = 1'b1; op = 3'd3; op1 = 32'd1000; op2 = 32'd10;
    @(posedge clk); #1; start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL kill_fix_pre: busy=%b required 1", busy);
    end
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      failures++;
      $display("FAIL kill_fix: busy=%b done=%b hi=%h lo=%h required 0 0 %h %h",
               busy, done, hi, lo, exp_hi, exp_lo);
    end
    @(negedge clk); kill = 1'b0;
    do_op(3'd6, 32'h5555_5555, 32'h3);
    checks++;
    if (dones !== 0 || lat !== 0 || hi !== exp_hi || lo !== exp_lo) begin
      failures++;
      $display("FAIL reserved_op: dones=%0d lat=%0d hi=%h lo=%h required 0 0 %h %h",
               dones, lat, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_async_reset();
    do_op(3'd5, 32'h1357_9BDF, 32'd0);
    @(negedge clk); start = 1'b1; op = 3'd3; op1 = 32'd1234; op2 = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    #3; reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h required all zero", busy, done, hi, lo);
    end
    @(negedge clk); reset = 1'b0;
    do_op(3'd3, 32'd9, 32'd3);
    checks++;
    if (lo !== 32'd3 || hi !== 32'd0 || lat !== 33 || dones !== 1) begin
      failures++;
      $display("FAIL post_reset_divu: hi=%h lo=%h lat=%0d dones=%0d required 0 3 33 1",
               hi, lo, lat, dones);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_kill();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
